// File: rtl/steering_pkg.sv
// Shared constants, register map and FSM encoding for the steering angle ramp block.
// Optional clamp feature is selected with STEERING_RAMP_CLAMP_EN.
package steering_pkg;

    localparam int unsigned ANGLE_W = 10;
    localparam logic [31:0] STEERING_ID = 32'hEA68_0004;

    localparam logic [2:0] ADDR_ID       = 3'd0;
    localparam logic [2:0] ADDR_TARGET   = 3'd1;
    localparam logic [2:0] ADDR_STEP     = 3'd2;
    localparam logic [2:0] ADDR_INTERVAL = 3'd3;
    localparam logic [2:0] ADDR_CTRL     = 3'd4;
    localparam logic [2:0] ADDR_STATUS   = 3'd5;
    localparam logic [2:0] ADDR_MIN      = 3'd6;
    localparam logic [2:0] ADDR_MAX      = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    // Merge a bus write into the current register value lane by lane.
    function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] v;
        v = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) v[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/steering_ramp_if.sv
// Avalon-MM control port of the steering ramp block.
interface steering_ramp_if;
    logic [31:0] avs_ctrl_writedata;
    logic [31:0] avs_ctrl_readdata;
    logic [3:0]  avs_ctrl_byteenable;
    logic [2:0]  avs_ctrl_address;
    logic        avs_ctrl_write;
    logic        avs_ctrl_read;
    logic        avs_ctrl_waitrequest;

    modport master (
        output avs_ctrl_writedata, avs_ctrl_byteenable, avs_ctrl_address,
               avs_ctrl_write, avs_ctrl_read,
        input  avs_ctrl_readdata, avs_ctrl_waitrequest
    );

    modport slave (
        input  avs_ctrl_writedata, avs_ctrl_byteenable, avs_ctrl_address,
               avs_ctrl_write, avs_ctrl_read,
        output avs_ctrl_readdata, avs_ctrl_waitrequest
    );
endinterface

// File: rtl/steering_tick_gen.sv
// Programmable prescaler: counts 0..i_interval and pulses o_tick for one cycle at the top.
module steering_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_restart,
    input  logic [DIV_W-1:0] i_interval,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    // >= rather than == so a shrinking interval cannot strand the counter above it.
    assign o_tick = !i_restart && (r_cnt >= i_interval);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/steering_ramp.sv
// Avalon-MM slave that slews angle_out toward a software target at a programmed step/interval.
// Define STEERING_RAMP_CLAMP_EN to add min/max target clamping (registers 6 and 7).
module steering_ramp
    import steering_pkg::*;
#(
    parameter logic [ANGLE_W-1:0] ANGLE_RESET = '0,
    parameter int unsigned        DIV_W       = 16,
    parameter logic [31:0]        ID_VALUE    = STEERING_ID
) (
    input  logic               csi_MCLK_clk,
    input  logic               rsi_MRST_reset_n,
    steering_ramp_if.slave     avs,
    output logic [ANGLE_W-1:0] angle_out,
    output logic               ramp_busy
);

    logic [ANGLE_W-1:0] r_target;
    logic [ANGLE_W-1:0] r_step;
    logic [DIV_W-1:0]   r_interval;
    logic               r_enable;
    logic [31:0]        r_rdata;
    state_t             r_state;

    logic               w_wr;
    logic               w_snap;
    logic               w_tick;
    logic               w_clamped;
    logic [31:0]        w_rd_mux;
    logic [31:0]        w_wr_val;
    logic [ANGLE_W-1:0] w_eff_target;
    logic [ANGLE_W-1:0] w_dist;
    logic [ANGLE_W-1:0] w_move;
    logic [ANGLE_W-1:0] w_stepped;
    logic               w_up;
    state_t             w_next_state;
    logic [ANGLE_W-1:0] w_next_angle;

    assign w_wr   = avs.avs_ctrl_write;
    assign w_snap = w_wr && (avs.avs_ctrl_address == ADDR_CTRL) &&
                    avs.avs_ctrl_byteenable[0] && avs.avs_ctrl_writedata[1];

`ifdef STEERING_RAMP_CLAMP_EN
    logic [ANGLE_W-1:0] r_min;
    logic [ANGLE_W-1:0] r_max;
    logic               r_clamped;

    function automatic logic [ANGLE_W-1:0] f_clamp(input logic [ANGLE_W-1:0] t,
                                                   input logic [ANGLE_W-1:0] lo,
                                                   input logic [ANGLE_W-1:0] hi);
        logic [ANGLE_W-1:0] v;
        if (lo > hi)      v = lo;
        else if (t < lo)  v = lo;
        else if (t > hi)  v = hi;
        else              v = t;
        return v;
    endfunction

    assign w_eff_target = f_clamp(r_target, r_min, r_max);
    assign w_clamped    = r_clamped;
`else
    assign w_eff_target = r_target;
    assign w_clamped    = 1'b0;
`endif

    // Read mux doubles as the "old value" for byte-lane merging on writes.
    always_comb begin
        w_rd_mux = '0;
        case (avs.avs_ctrl_address)
            ADDR_ID:       w_rd_mux = ID_VALUE;
            ADDR_TARGET:   w_rd_mux = 32'(r_target);
            ADDR_STEP:     w_rd_mux = 32'(r_step);
            ADDR_INTERVAL: w_rd_mux = 32'(r_interval);
            ADDR_CTRL:     w_rd_mux = {31'b0, r_enable};
            ADDR_STATUS:   w_rd_mux = {{(32-ANGLE_W-2){1'b0}}, ramp_busy, w_clamped, angle_out};
`ifdef STEERING_RAMP_CLAMP_EN
            ADDR_MIN:      w_rd_mux = 32'(r_min);
            ADDR_MAX:      w_rd_mux = 32'(r_max);
`endif
            default:       w_rd_mux = '0;
        endcase
    end

    assign w_wr_val = apply_be(w_rd_mux, avs.avs_ctrl_writedata, avs.avs_ctrl_byteenable);

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_target   <= ANGLE_RESET;
            r_step     <= ANGLE_W'(1);
            r_interval <= '0;
            r_enable   <= 1'b0;
            r_rdata    <= '0;
`ifdef STEERING_RAMP_CLAMP_EN
            r_min      <= '0;
            r_max      <= '1;
            r_clamped  <= 1'b0;
`endif
        end else begin
            if (w_wr) begin
                case (avs.avs_ctrl_address)
                    ADDR_TARGET: begin
                        r_target <= w_wr_val[ANGLE_W-1:0];
`ifdef STEERING_RAMP_CLAMP_EN
                        r_clamped <= (f_clamp(w_wr_val[ANGLE_W-1:0], r_min, r_max)
                                      != w_wr_val[ANGLE_W-1:0]);
`endif
                    end
                    ADDR_STEP:     r_step     <= w_wr_val[ANGLE_W-1:0];
                    ADDR_INTERVAL: r_interval <= w_wr_val[DIV_W-1:0];
                    ADDR_CTRL:     r_enable   <= w_wr_val[0];
`ifdef STEERING_RAMP_CLAMP_EN
                    ADDR_MIN:      r_min      <= w_wr_val[ANGLE_W-1:0];
                    ADDR_MAX:      r_max      <= w_wr_val[ANGLE_W-1:0];
`endif
                    default: ;
                endcase
            end
            if (avs.avs_ctrl_read && !avs.avs_ctrl_write) begin
                r_rdata <= w_rd_mux;
            end
        end
    end

    assign avs.avs_ctrl_readdata    = r_rdata;
    assign avs.avs_ctrl_waitrequest = 1'b0;

    steering_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .i_clk      (csi_MCLK_clk),
        .i_rst_n    (rsi_MRST_reset_n),
        .i_restart  (w_wr && (avs.avs_ctrl_address == ADDR_INTERVAL)),
        .i_interval (r_interval),
        .o_tick     (w_tick)
    );

    // Step is limited to the remaining distance, so no overshoot and no wrap.
    assign w_up      = (w_eff_target > angle_out);
    assign w_dist    = w_up ? (w_eff_target - angle_out) : (angle_out - w_eff_target);
    assign w_move    = (r_step < w_dist) ? r_step : w_dist;
    assign w_stepped = w_up ? (angle_out + w_move) : (angle_out - w_move);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_angle = angle_out;
        if (w_snap) begin
            w_next_angle = w_eff_target;
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_enable && (angle_out != w_eff_target)) w_next_state = ST_RAMP;
                end
                ST_RAMP: begin
                    if (!r_enable || (angle_out == w_eff_target)) begin
                        w_next_state = ST_IDLE;
                    end else if (w_tick) begin
                        w_next_angle = w_stepped;
                        if (w_stepped == w_eff_target) w_next_state = ST_IDLE;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            r_state   <= ST_IDLE;
            angle_out <= ANGLE_RESET;
            ramp_busy <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            angle_out <= w_next_angle;
            ramp_busy <= (w_next_state == ST_RAMP);
        end
    end

endmodule

// File: tb/tb_steering_ramp.sv
// Directed testbench for steering_ramp: register table plus hand-written ramp sequences.
module tb_steering_ramp;
    import steering_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [9:0] angle;
    logic       busy;
    int         n_cmp;
    int         n_err;

    steering_ramp_if bus ();

    steering_ramp dut (
        .csi_MCLK_clk     (clk),
        .rsi_MRST_reset_n (rst_n),
        .avs              (bus),
        .angle_out        (angle),
        .ramp_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        bus.avs_ctrl_address    = a;
        bus.avs_ctrl_writedata  = d;
        bus.avs_ctrl_byteenable = be;
        bus.avs_ctrl_write      = 1'b1;
        @(negedge clk);
        bus.avs_ctrl_write      = 1'b0;
        bus.avs_ctrl_byteenable = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.avs_ctrl_address = a;
        bus.avs_ctrl_read    = 1'b1;
        @(negedge clk);
        bus.avs_ctrl_read    = 1'b0;
        d = bus.avs_ctrl_readdata;
    endtask

    // Wait (bounded) for angle_out to leave prev; reports new value and cycles waited.
    task automatic wait_change(input string name, input logic [9:0] prev, input int budget,
                               output logic [9:0] val, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (angle == prev && cyc < budget);
        val = angle;
        if (angle == prev) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout, angle stuck at %0d after %0d cycles", name, prev, cyc);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  v;
        logic [9:0]  vmax;
        int          cyc;

        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.avs_ctrl_address    = '0;
        bus.avs_ctrl_writedata  = '0;
        bus.avs_ctrl_byteenable = '0;
        bus.avs_ctrl_write      = 1'b0;
        bus.avs_ctrl_read       = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_angle", 32'(angle), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", bus.avs_ctrl_readdata, 32'd0);
        check("waitrequest", 32'(bus.avs_ctrl_waitrequest), 32'd0);
        rst_n = 1'b1;

        // Register map and byte-lane behaviour
        vecs.push_back('{1'b0, ADDR_ID,       32'h0,         4'hF, 32'hEA68_0004});
        vecs.push_back('{1'b1, ADDR_STEP,     32'h5,         4'hF, 32'h5});
        vecs.push_back('{1'b1, ADDR_INTERVAL, 32'h0001_2345, 4'hF, 32'h2345});
        vecs.push_back('{1'b1, ADDR_TARGET,   32'hFFFF_F0AB, 4'hF, 32'h0AB});
        vecs.push_back('{1'b1, ADDR_TARGET,   32'h0000_03FF, 4'b0001, 32'h0FF});
        vecs.push_back('{1'b1, ADDR_TARGET,   32'h0000_0300, 4'b0010, 32'h3FF});
        vecs.push_back('{1'b1, ADDR_TARGET,   32'h0,         4'b0000, 32'h3FF});
        vecs.push_back('{1'b1, ADDR_CTRL,     32'h0,         4'hF, 32'h0});
        vecs.push_back('{1'b0, ADDR_STATUS,   32'h0,         4'hF, 32'h0});
        vecs.push_back('{1'b1, ADDR_STATUS,   32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{1'b1, ADDR_ID,       32'h0,         4'hF, 32'hEA68_0004});
`ifdef STEERING_RAMP_CLAMP_EN
        vecs.push_back('{1'b0, ADDR_MIN,      32'h0,         4'hF, 32'h0});
        vecs.push_back('{1'b0, ADDR_MAX,      32'h0,         4'hF, 32'h3FF});
`else
        vecs.push_back('{1'b1, ADDR_MIN,      32'h3FF,       4'hF, 32'h0});
        vecs.push_back('{1'b1, ADDR_MAX,      32'h3FF,       4'hF, 32'h0});
`endif
        foreach (vecs[i]) begin
            if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            bus_read(vecs[i].addr, rd);
            check($sformatf("reg_vec%0d_addr%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end
        check("table_angle_idle", 32'(angle), 32'd0);

        // Ramp up 0 -> 10, step 4, tick every 10 cycles
        bus_write(ADDR_TARGET, 32'd0, 4'hF);
        bus_write(ADDR_STEP, 32'd4, 4'hF);
        bus_write(ADDR_INTERVAL, 32'd9, 4'hF);
        bus_write(ADDR_TARGET, 32'd10, 4'hF);
        bus_write(ADDR_CTRL, 32'd1, 4'hF);
        wait_change("up1", 10'd0, 40, v, cyc);
        check("up1_val", 32'(v), 32'd4);
        check("up1_busy", 32'(busy), 32'd1);
        wait_change("up2", v, 40, v, cyc);
        check("up2_val", 32'(v), 32'd8);
        check("up2_gap", 32'(cyc), 32'd10);
        wait_change("up3", v, 40, v, cyc);
        check("up3_val", 32'(v), 32'd10);
        check("up3_gap", 32'(cyc), 32'd10);
        check("up3_busy", 32'(busy), 32'd0);

        // Snap to 100, ramp down to 50 by 30
        bus_write(ADDR_TARGET, 32'd100, 4'hF);
        bus_write(ADDR_CTRL, 32'd3, 4'hF);
        check("snap100", 32'(angle), 32'd100);
        check("snap100_busy", 32'(busy), 32'd0);
        bus_write(ADDR_STEP, 32'd30, 4'hF);
        bus_write(ADDR_TARGET, 32'd50, 4'hF);
        wait_change("dn1", 10'd100, 40, v, cyc);
        check("dn1_val", 32'(v), 32'd70);
        wait_change("dn2", v, 40, v, cyc);
        check("dn2_val", 32'(v), 32'd50);
        check("dn2_busy", 32'(busy), 32'd0);

        // Retarget mid-ramp: heading to 10, then reverse to 200
        bus_write(ADDR_TARGET, 32'd10, 4'hF);
        wait_change("rt1", 10'd50, 40, v, cyc);
        check("rt1_val", 32'(v), 32'd20);
        bus_write(ADDR_TARGET, 32'd200, 4'hF);
        wait_change("rt2", v, 40, v, cyc);
        check("rt2_reverse", 32'(v), 32'd50);
        vmax = v;
        for (int i = 0; i < 10 && angle != 10'd200; i++) begin
            wait_change("rt_up", angle, 40, v, cyc);
            if (v > vmax) vmax = v;
        end
        check("rt_final", 32'(angle), 32'd200);
        check("rt_no_overshoot", 32'(vmax), 32'd200);
        check("rt_busy", 32'(busy), 32'd0);

        // Disable freezes, snap jumps to target
        bus_write(ADDR_TARGET, 32'd0, 4'hF);
        wait_change("dis1", 10'd200, 40, v, cyc);
        check("dis1_val", 32'(v), 32'd170);
        bus_write(ADDR_CTRL, 32'd0, 4'hF);
        repeat (30) @(negedge clk);
        check("dis_frozen", 32'(angle), 32'd170);
        check("dis_busy", 32'(busy), 32'd0);
        bus_write(ADDR_CTRL, 32'd2, 4'hF);
        check("snap0", 32'(angle), 32'd0);
        bus_read(ADDR_CTRL, rd);
        check("snap_selfclear", rd, 32'd0);

        // step = 0 holds while busy
        bus_write(ADDR_STEP, 32'd0, 4'hF);
        bus_write(ADDR_TARGET, 32'd50, 4'hF);
        bus_write(ADDR_CTRL, 32'd1, 4'hF);
        repeat (30) @(negedge clk);
        check("step0_angle", 32'(angle), 32'd0);
        check("step0_busy", 32'(busy), 32'd1);
        bus_read(ADDR_STATUS, rd);
        check("step0_status", rd, 32'h800);

        // Asynchronous reset mid-ramp
        bus_write(ADDR_STEP, 32'd1, 4'hF);
        bus_write(ADDR_INTERVAL, 32'd0, 4'hF);
        bus_write(ADDR_TARGET, 32'd500, 4'hF);
        repeat (5) @(negedge clk);
        bus_read(ADDR_ID, rd);
        check("pre_rst_id", rd, 32'hEA68_0004);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_angle", 32'(angle), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_rdata", bus.avs_ctrl_readdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef STEERING_RAMP_CLAMP_EN
        bus_write(ADDR_MIN, 32'd100, 4'hF);
        bus_write(ADDR_MAX, 32'd900, 4'hF);
        bus_write(ADDR_STEP, 32'd1023, 4'hF);
        bus_write(ADDR_TARGET, 32'd1000, 4'hF);
        bus_write(ADDR_CTRL, 32'd1, 4'hF);
        for (int i = 0; i < 20 && angle != 10'd900; i++) @(negedge clk);
        @(negedge clk);
        check("clamp_angle", 32'(angle), 32'd900);
        bus_read(ADDR_STATUS, rd);
        check("clamp_status", rd, 32'h784);
        bus_write(ADDR_MIN, 32'd950, 4'hF);
        for (int i = 0; i < 20 && angle != 10'd950; i++) @(negedge clk);
        @(negedge clk);
        check("clamp_min_gt_max", 32'(angle), 32'd950);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
